// File: rtl/vreg_pkg.sv
// vreg_pkg: shared defaults, state type and lane helpers for the vector register file.
package vreg_pkg;

  localparam int DEF_LANES  = 4;
  localparam int DEF_ELEM_W = 32;
  localparam int DEF_NREGS  = 32;

  typedef enum logic {VR_IDLE, VR_CLEAR} vreg_state_t;

  // Bit offset of the lowest bit of a lane inside a register word.
  function automatic int lane_lo(input int lane, input int elem_w);
    return lane * elem_w;
  endfunction

endpackage

// File: rtl/vreg_lane_merge.sv
// vreg_lane_merge: builds a register word lane by lane, taking each lane from
// new_data where its mask bit is set and from old_data otherwise.
module vreg_lane_merge
  import vreg_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int ELEM_W = DEF_ELEM_W
) (
  input  logic [LANES*ELEM_W-1:0] old_data,
  input  logic [LANES*ELEM_W-1:0] new_data,
  input  logic [LANES-1:0]        mask,
  output logic [LANES*ELEM_W-1:0] merged
);

  // Overlay the masked lanes of the new word onto the old word
  always_comb begin
    merged = old_data;
    for (int i = 0; i < LANES; i++) begin
      if (mask[i]) begin
        merged[lane_lo(i, ELEM_W) +: ELEM_W] = new_data[lane_lo(i, ELEM_W) +: ELEM_W];
      end
    end
  end

endmodule

// File: rtl/vreg_file_lanes.sv
// vreg_file_lanes: NREGS x (LANES*ELEM_W) vector register file with two operand
// read ports, a writeback read port, one lane-masked write port and a hardware
// clear sweep that zeroes every register after reset or on request.
// Optional feature: define VREG_BYPASS_EN for same-cycle write-through on reads.
module vreg_file_lanes
  import vreg_pkg::*;
#(
  parameter int  LANES  = DEF_LANES,
  parameter int  ELEM_W = DEF_ELEM_W,
  parameter int  NREGS  = DEF_NREGS,
  localparam int AW     = $clog2(NREGS),
  localparam int RW     = LANES * ELEM_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  output logic             busy,
  input  logic             wre,
  input  logic [LANES-1:0] wmask,
  input  logic [AW-1:0]    a1,
  input  logic [AW-1:0]    a2,
  input  logic [AW-1:0]    a3,
  input  logic [RW-1:0]    wd3,
  output logic [RW-1:0]    rd1,
  output logic [RW-1:0]    rd2,
  output logic [RW-1:0]    rd3
);

  logic [RW-1:0] rf [NREGS];
  vreg_state_t   state;
  logic [AW-1:0] cidx;
  logic [RW-1:0] wmerged;
  logic          arr_we;
  logic [AW-1:0] arr_addr;
  logic [RW-1:0] arr_data;
  logic [RW-1:0] rv1, rv2, rv3;

  assign busy = (state == VR_CLEAR);

  vreg_lane_merge #(.LANES(LANES), .ELEM_W(ELEM_W)) u_wmerge (
    .old_data(rf[a3]),
    .new_data(wd3),
    .mask    (wmask),
    .merged  (wmerged)
  );

  // Run the clear sweep one register per cycle, then sit in idle until asked again
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= VR_CLEAR;
      cidx  <= '0;
    end else begin
      case (state)
        VR_CLEAR: begin
          if (cidx == AW'(NREGS - 1)) begin
            state <= VR_IDLE;
            cidx  <= '0;
          end else begin
            cidx <= cidx + AW'(1);
          end
        end
        default: begin
          if (clr) begin
            state <= VR_CLEAR;
            cidx  <= '0;
          end
        end
      endcase
    end
  end

  // Pick the array write: a zero at cidx while sweeping, else the merged user write (clr wins)
  always_comb begin
    arr_we   = 1'b0;
    arr_addr = a3;
    arr_data = wmerged;
    if (rst_n) begin
      if (busy) begin
        arr_we   = 1'b1;
        arr_addr = cidx;
        arr_data = '0;
      end else if (wre && !clr) begin
        arr_we = 1'b1;
      end
    end
  end

  // Single write port into the storage array; contents are never reset directly
  always_ff @(posedge clk) begin
    if (arr_we) begin
      rf[arr_addr] <= arr_data;
    end
  end

`ifdef VREG_BYPASS_EN
  logic             byp_on;
  logic [LANES-1:0] bmask1, bmask2, bmask3;

  assign byp_on = !busy && wre && !clr;
  assign bmask1 = (byp_on && (a1 == a3)) ? wmask : '0;
  assign bmask2 = (byp_on && (a2 == a3)) ? wmask : '0;
  assign bmask3 = byp_on ? wmask : '0;

  vreg_lane_merge #(.LANES(LANES), .ELEM_W(ELEM_W)) u_byp1 (
    .old_data(rf[a1]), .new_data(wd3), .mask(bmask1), .merged(rv1)
  );
  vreg_lane_merge #(.LANES(LANES), .ELEM_W(ELEM_W)) u_byp2 (
    .old_data(rf[a2]), .new_data(wd3), .mask(bmask2), .merged(rv2)
  );
  vreg_lane_merge #(.LANES(LANES), .ELEM_W(ELEM_W)) u_byp3 (
    .old_data(rf[a3]), .new_data(wd3), .mask(bmask3), .merged(rv3)
  );
`else
  assign rv1 = rf[a1];
  assign rv2 = rf[a2];
  assign rv3 = rf[a3];
`endif

  assign rd1 = busy ? '0 : rv1;
  assign rd2 = busy ? '0 : rv2;
  assign rd3 = busy ? '0 : rv3;

endmodule

// File: tb/tb_vreg_file_lanes.sv
// tb_vreg_file_lanes: randomized self-checking bench for vreg_file_lanes with a
// behavioural register-file model; a second instance covers a non-default shape.
module tb_vreg_file_lanes;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst_n, clr, wre, busy;
  logic [3:0]   wmask;
  logic [4:0]   a1, a2, a3;
  logic [127:0] wd3, rd1, rd2, rd3;

  logic         p_rst_n, p_clr, p_wre, p_busy;
  logic [7:0]   p_wmask;
  logic [3:0]   p_a1, p_a2, p_a3;
  logic [127:0] p_wd3, p_rd1, p_rd2, p_rd3;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: register contents, sweep flag and remaining sweep edges
  logic [127:0] mem [N];
  bit           m_busy;
  int           m_left;

  always #5 clk = ~clk;

  vreg_file_lanes dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy), .wre(wre), .wmask(wmask),
    .a1(a1), .a2(a2), .a3(a3), .wd3(wd3), .rd1(rd1), .rd2(rd2), .rd3(rd3)
  );

  vreg_file_lanes #(.LANES(8), .ELEM_W(16), .NREGS(16)) dut_p (
    .clk(clk), .rst_n(p_rst_n), .clr(p_clr), .busy(p_busy), .wre(p_wre), .wmask(p_wmask),
    .a1(p_a1), .a2(p_a2), .a3(p_a3), .wd3(p_wd3), .rd1(p_rd1), .rd2(p_rd2), .rd3(p_rd3)
  );

  function automatic logic [127:0] lane_merge(input logic [127:0] old, input logic [127:0] nw,
                                              input logic [3:0] m);
    logic [127:0] v;
    v = old;
    for (int i = 0; i < 4; i++) if (m[i]) v[i*32 +: 32] = nw[i*32 +: 32];
    return v;
  endfunction

  // Value a read port should show right now for address a
  function automatic logic [127:0] exp_rd(input logic [4:0] a);
    logic [127:0] v;
    if (m_busy) return '0;
    v = mem[a];
`ifdef VREG_BYPASS_EN
    if (wre && !clr && a == a3) v = lane_merge(v, wd3, wmask);
`endif
    return v;
  endfunction

  // Advance one clock edge and apply the same edge to the model
  task automatic cycle();
    @(posedge clk);
    if (!rst_n) begin
      m_busy = 1'b1;
      m_left = N;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0;
        for (int i = 0; i < N; i++) mem[i] = '0;
      end
    end else if (clr) begin
      m_busy = 1'b1;
      m_left = N;
    end else if (wre) begin
      mem[a3] = lane_merge(mem[a3], wd3, wmask);
    end
    #1;
  endtask

  task automatic idle_inputs();
    clr = 1'b0; wre = 1'b0; wmask = '0; wd3 = '0;
  endtask

  task automatic test_reset();
    int cnt;
    rst_n = 1'b0;
    idle_inputs();
    a1 = '0; a2 = '0; a3 = '0;
    cycle();
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("[TB] FAIL reset_busy got=%0b want=1", busy);
    end
    cycle();
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!busy) break;
      if (cnt == 0) begin
        checks++;
        if ((rd1 | rd2 | rd3) !== '0) begin
          failures++; $display("[TB] FAIL reset_reads got=%h want=0", rd1 | rd2 | rd3);
        end
      end
      cnt++;
      cycle();
    end
    checks++;
    if (cnt != N) begin
      failures++; $display("[TB] FAIL reset_busy_len got=%0d want=%0d", cnt, N);
    end
    cycle();
    for (int i = 0; i < N; i++) begin
      a1 = 5'(i); a2 = 5'(N - 1 - i); a3 = 5'(i);
      @(negedge clk);
      checks++;
      if (rd1 !== exp_rd(a1) || rd2 !== exp_rd(a2) || rd3 !== exp_rd(a3)) begin
        failures++;
        $display("[TB] FAIL reset_zero reg=%0d got=%h/%h/%h want=0", i, rd1, rd2, rd3);
      end
      cycle();
    end
  endtask

  task automatic test_masked_write();
    wre = 1'b1; a3 = 5'd5; wmask = 4'b1111;
    wd3 = 128'h44444444_33333333_22222222_11111111;
    cycle();
    wd3 = '1; wmask = 4'b0101;
    cycle();
    idle_inputs();
    a1 = 5'd5; a3 = 5'd5;
    @(negedge clk);
    checks++;
    if (rd1 !== 128'h44444444_FFFFFFFF_22222222_FFFFFFFF) begin
      failures++;
      $display("[TB] FAIL masked_write got=%h want=44444444ffffffff22222222ffffffff", rd1);
    end
    checks++;
    if (rd3 !== 128'h44444444_FFFFFFFF_22222222_FFFFFFFF) begin
      failures++; $display("[TB] FAIL masked_write_rd3 got=%h", rd3);
    end
    cycle();
    wre = 1'b1; wmask = 4'b0000; wd3 = '0;
    cycle();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (rd1 !== 128'h44444444_FFFFFFFF_22222222_FFFFFFFF) begin
      failures++; $display("[TB] FAIL zero_mask_noop got=%h", rd1);
    end
    cycle();
  endtask

  task automatic test_bypass();
    logic [127:0] want;
    wre = 1'b1; a3 = 5'd7; a1 = 5'd7; a2 = 5'd6; wmask = 4'b0010;
    wd3 = {32'h13572468, 32'h9ABCDEF0, 32'hDEADBEEF, 32'h0F0F0F0F};
`ifdef VREG_BYPASS_EN
    want = 128'h00000000_00000000_DEADBEEF_00000000;
`else
    want = '0;
`endif
    @(negedge clk);
    checks++;
    if (rd1 !== want) begin
      failures++; $display("[TB] FAIL bypass_same_cycle got=%h want=%h", rd1, want);
    end
    checks++;
    if (rd2 !== exp_rd(a2)) begin
      failures++; $display("[TB] FAIL bypass_other_port got=%h want=%h", rd2, exp_rd(a2));
    end
    cycle();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (rd1 !== 128'h00000000_00000000_DEADBEEF_00000000) begin
      failures++; $display("[TB] FAIL bypass_next_cycle got=%h", rd1);
    end
    cycle();
  endtask

  task automatic test_random();
    for (int k = 0; k < 200; k++) begin
      wre = 1'($urandom); wmask = 4'($urandom);
      a1 = 5'($urandom); a2 = 5'($urandom); a3 = 5'($urandom);
      if (k % 3 == 0) a1 = a3;
      wd3 = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      checks++;
      if (rd1 !== exp_rd(a1) || rd2 !== exp_rd(a2) || rd3 !== exp_rd(a3)) begin
        failures++;
        $display("[TB] FAIL random k=%0d got=%h/%h/%h want=%h/%h/%h", k, rd1, rd2, rd3,
                 exp_rd(a1), exp_rd(a2), exp_rd(a3));
      end
      cycle();
    end
    idle_inputs();
  endtask

  task automatic test_clear_collision();
    int cnt;
    for (int i = 0; i < N; i++) begin
      wre = 1'b1; a3 = 5'(i); wmask = 4'hF;
      wd3 = {$urandom, $urandom, $urandom, $urandom} | 128'h1;
      cycle();
    end
    clr = 1'b1; wre = 1'b1; a3 = 5'd3; wmask = 4'hF; wd3 = '1;
    cycle();
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!busy) break;
      if (cnt == 0) begin
        checks++;
        if ((rd1 | rd2 | rd3) !== '0) begin
          failures++; $display("[TB] FAIL clear_reads got=%h want=0", rd1 | rd2 | rd3);
        end
      end
      cnt++;
      wre = 1'b1; clr = 1'($urandom); wmask = 4'($urandom);
      a1 = 5'($urandom); a3 = 5'($urandom); wd3 = {$urandom, $urandom, $urandom, $urandom};
      cycle();
    end
    idle_inputs();
    checks++;
    if (cnt != N) begin
      failures++; $display("[TB] FAIL clear_busy_len got=%0d want=%0d", cnt, N);
    end
    cycle();
    for (int i = 0; i < N; i++) begin
      a1 = 5'(i); a2 = 5'(i ^ 1); a3 = 5'(N - 1 - i);
      @(negedge clk);
      checks++;
      if (rd1 !== '0 || rd2 !== '0 || rd3 !== '0) begin
        failures++; $display("[TB] FAIL clear_zero reg=%0d got=%h/%h/%h want=0", i, rd1, rd2, rd3);
      end
      cycle();
    end
  endtask

  task automatic test_reset_mid_sweep();
    int cnt;
    wre = 1'b1; a3 = 5'd9; wmask = 4'hF; wd3 = 128'hA5;
    cycle();
    idle_inputs();
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    for (int k = 0; k < 10; k++) cycle();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("[TB] FAIL midsweep_busy got=%0b want=1", busy);
    end
    cycle();
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
      cycle();
    end
    checks++;
    if (cnt != N) begin
      failures++; $display("[TB] FAIL midsweep_busy_len got=%0d want=%0d", cnt, N);
    end
    cycle();
    a1 = 5'd9;
    @(negedge clk);
    checks++;
    if (rd1 !== '0) begin
      failures++; $display("[TB] FAIL midsweep_zero got=%h want=0", rd1);
    end
    cycle();
  endtask

  task automatic test_param();
    int cnt;
    logic [127:0] first;
    p_rst_n = 1'b0;
    cycle();
    cycle();
    p_rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!p_busy) break;
      cnt++;
      cycle();
    end
    checks++;
    if (cnt != 16) begin
      failures++; $display("[TB] FAIL param_busy_len got=%0d want=16", cnt);
    end
    first = {$urandom, $urandom, $urandom, $urandom};
    p_wre = 1'b1; p_a3 = 4'd2; p_wmask = 8'hFF; p_wd3 = first;
    cycle();
    p_wd3 = '1; p_wmask = 8'h80;
    cycle();
    p_wre = 1'b0; p_a1 = 4'd2; p_a2 = 4'd0; p_a3 = 4'd2;
    @(negedge clk);
    checks++;
    if (p_rd1 !== {16'hFFFF, first[111:0]}) begin
      failures++; $display("[TB] FAIL param_mask_msb got=%h want=%h", p_rd1, {16'hFFFF, first[111:0]});
    end
    checks++;
    if (p_rd2 !== '0) begin
      failures++; $display("[TB] FAIL param_other_reg got=%h want=0", p_rd2);
    end
    cycle();
  endtask

  initial begin
    p_rst_n = 1'b0; p_clr = 1'b0; p_wre = 1'b0; p_wmask = '0;
    p_a1 = '0; p_a2 = '0; p_a3 = '0; p_wd3 = '0;
    m_busy = 1'b1; m_left = N;
    for (int i = 0; i < N; i++) mem[i] = '0;
    test_reset();
    test_masked_write();
    test_bypass();
    test_random();
    test_clear_collision();
    test_reset_mid_sweep();
    test_param();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
